reg_bank_arbiter: RTL and testbench
===================================

Name: reg_bank_arbiter

Overview:
- Shared bank of NUM_REGS 32-bit registers with one write port, time-shared between NUM_REQ requesters by a round-robin arbiter.
- Supports an atomic lock: a requester can hold the write port across cycles for read-modify-write sequences.
- Sits between ALU issue units and the register storage.
- Provides one combinational read port for the datapath.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- NUM_REGS, 8, number of 32-bit registers (power of 2).
- AW, $clog2(NUM_REGS), register address width.
- LOCK_MAX, 16, maximum cycles a lock may be held before forced release.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_lock  input  NUM_REQ  per-requester request to hold the grant after this write.
- req_addr  input  NUM_REQ*AW  flattened register addresses; requester i uses slice [i*AW +: AW].
- req_data  input  NUM_REQ*32  flattened write data; requester i uses slice [i*32 +: 32].
- req_ready  output  NUM_REQ  one-hot grant; write accepted when valid & ready.
- rd_addr  input  AW  read address.
- rd_data  output  32  combinational read of the register at rd_addr.
- lock_active  output  1  the write port is locked to lock_owner.
- lock_owner  output  $clog2(NUM_REQ)  current lock holder; 0 when unlocked.
- lock_timeout  output  1  one-cycle pulse when a lock is force-released.

Behaviour:
- Reset (async assert, sync deassert):
  - All registers 32'h0; rr_ptr=0; state=IDLE.
  - lock_active=0, lock_owner=0, lock_timeout=0, req_ready=0.
- States:
  - IDLE: round-robin grant.
  - LOCKED: grant fixed to lock_owner.
- IDLE grant rules:
  - req_ready is combinational: at most one bit set, the first valid requester at or after rr_ptr, with wrap-around.
  - If no requester is valid, req_ready=0.
- Write: on the posedge where req_valid[g] & req_ready[g], reg[req_addr[g]] <= req_data[g]. Registers are unchanged in all other cycles.
- Pointer: after an accepted write in IDLE, rr_ptr <= (g+1) mod NUM_REQ. rr_ptr never moves without a grant.
- IDLE -> LOCKED: when the accepted write has req_lock[g]=1. Then lock_owner<=g, lock_active<=1, lock_cnt<=0.
- LOCKED grant rules:
  - req_ready[lock_owner] = req_valid[lock_owner]; all other ready bits are 0.
  - Other requesters stall with no side effects.
- LOCKED -> IDLE, on either of:
  - an accepted owner write with req_lock[owner]=0 (that write is performed), or
  - the owner deasserts both req_valid and req_lock in the same cycle.
  - On exit, rr_ptr <= owner+1.
- Timeout:
  - lock_cnt increments every LOCKED cycle.
  - When lock_cnt == LOCK_MAX-1 with no release, force IDLE next cycle and pulse lock_timeout for 1 cycle. rr_ptr <= owner+1.
  - A write accepted in that final cycle is still performed.
- Read: rd_data = reg[rd_addr], combinational, showing the old value in the cycle a write to the same address is accepted (no bypass unless the optional feature is enabled).
- Out-of-range addresses cannot occur because NUM_REGS is a power of 2.
- Reset asserted mid-lock clears the lock immediately and does not complete a pending write.

Optional Feature:
- RD_BYPASS_EN
  - Defined: when a write is accepted this cycle and req_addr[g]==rd_addr, rd_data = req_data[g] (write-through forwarding).
  - Undefined: rd_data always reflects stored register contents only.

Decomposition:
- Package reg_bank_pkg holds:
  - localparam DATA_W=32;
  - typedef enum logic {IDLE, LOCKED} arb_state_t;
  - typedef logic [DATA_W-1:0] word_t.
- Sub-module rr_arbiter: request vector + pointer in, one-hot grant + encoded index out, combinational.
- Storage: a generate loop of per-register write-enabled flops.

Test Plan:
1. Reset, then read all addresses -> rd_data=0 everywhere; req_ready=0, lock_active=0.
2. All 4 valid, no lock, addr=i, data=32'hA0+i, held 4 cycles -> grants 0,1,2,3 in order; reg[i]=32'hA0+i.
3. rr_ptr=2, only requesters 0 and 3 valid -> grant 3, then 0 (wrap-around).
4. Requester 1 writes with lock=1 while all are valid, then 3 more locked writes to addr 5 -> only requester 1 granted. A final write with lock=0 releases; the next grant goes to requester 2.
5. Requester 0 holds lock=1 for 20 cycles, LOCK_MAX=16 -> lock_timeout pulses once at cycle 16; then requester 1 is granted.
6. Write 32'hDEADBEEF to addr 3 with rd_addr=3 -> same cycle rd_data=0 (bypass off) or 32'hDEADBEEF (RD_BYPASS_EN); next cycle 32'hDEADBEEF in both builds.
7. Assert rst_n low during LOCKED -> lock_active falls asynchronously, and the registers read 0 after reset.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types for the arbitrated register bank.
// Optional write-through read forwarding is enabled with RD_BYPASS_EN.
package reg_bank_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr,
// wrapping around.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank with a round-robin, lockable write port.
// Define RD_BYPASS_EN to forward an accepted write to the read port.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int LOCK_MAX = 16,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*AW-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [AW-1:0]             rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      lock_active,
    output logic [IW-1:0]             lock_owner,
    output logic                      lock_timeout
);

    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    arb_state_t state, state_nx;

    logic [IW-1:0]      rr_ptr, rr_ptr_nx;
    logic [IW-1:0]      owner, owner_nx;
    logic [IW-1:0]      arb_idx, gidx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               to_nx, rel;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    word_t              wr_data;
    word_t              regs [NUM_REGS];

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
        return (p == IW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        req_ready = '0;
        gidx      = arb_idx;
        if (state == LOCKED) begin
            gidx             = owner;
            req_ready[owner] = req_valid[owner];
        end else begin
            req_ready = arb_gnt;
        end
        wr_en   = |(req_valid & req_ready);
        wr_addr = req_addr[gidx*AW +: AW];
        wr_data = req_data[gidx*DATA_W +: DATA_W];
    end

    always_comb begin
        state_nx  = state;
        rr_ptr_nx = rr_ptr;
        owner_nx  = owner;
        cnt_nx    = cnt;
        to_nx     = 1'b0;
        rel       = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_en) begin
                    rr_ptr_nx = nxt(gidx);
                    if (req_lock[gidx]) begin
                        state_nx = LOCKED;
                        owner_nx = gidx;
                        cnt_nx   = '0;
                    end
                end
            end
            LOCKED: begin
                // Owner leaves by an unlocked write or by dropping both lines
                rel = (wr_en && !req_lock[owner]) ||
                      (!req_valid[owner] && !req_lock[owner]);
                if (rel || cnt == CW'(LOCK_MAX - 1)) begin
                    state_nx  = IDLE;
                    owner_nx  = '0;
                    rr_ptr_nx = nxt(owner);
                    to_nx     = !rel;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            cnt          <= '0;
            lock_timeout <= 1'b0;
        end else begin
            state        <= state_nx;
            rr_ptr       <= rr_ptr_nx;
            owner        <= owner_nx;
            cnt          <= cnt_nx;
            lock_timeout <= to_nx;
        end
    end

    assign lock_active = (state == LOCKED);
    assign lock_owner  = owner;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        word_t q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (wr_en && wr_addr == AW'(r)) begin
                q <= wr_data;
            end
        end
        assign regs[r] = q;
    end

    always_comb begin
        rd_data = regs[rd_addr];
`ifdef RD_BYPASS_EN
        if (wr_en && wr_addr == rd_addr) begin
            rd_data = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Vector table plus hand sequences; committed writes are checked
// against a scoreboard queue one cycle after acceptance.
module tb_reg_bank_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_lock;
    logic [11:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [2:0]   rd_addr;
    logic [31:0]  rd_data;
    logic         lock_active;
    logic [1:0]   lock_owner;
    logic         lock_timeout;

    reg_bank_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_lock     (req_lock),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .lock_active  (lock_active),
        .lock_owner   (lock_owner),
        .lock_timeout (lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [11:0] a;
        logic [31:0] d;
        logic [2:0]  ra;
        logic [3:0]  er;
        logic        ea;
        logic [1:0]  eo;
        logic        et;
    } vec_t;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
    } wr_t;

    int          n_cmp;
    int          n_bad;
    logic [31:0] model [8];
    wr_t         sbq [$];
    vec_t        tbl [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_pop();
        wr_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            req_valid = '0;
            rd_addr   = e.a;
            #1;
            chk("sb_write", rd_data, e.d);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] l,
                        input logic [11:0] a, input logic [31:0] d,
                        input logic [2:0] ra, input logic [3:0] er,
                        input logic ea, input logic [1:0] eo,
                        input logic et);
        logic [31:0] exp_rd;
        wr_t         w;
        int          g;
        sb_pop();
        req_valid = v;
        req_lock  = l;
        req_addr  = a;
        for (int i = 0; i < 4; i++) begin
            req_data[i*32 +: 32] = d + i;
        end
        rd_addr = ra;
        #1;
        g = -1;
        for (int i = 0; i < 4; i++) begin
            if (er[i]) g = i;
        end
        exp_rd = model[ra];
        if (g >= 0) begin
            w.a = a[g*3 +: 3];
            w.d = d + g;
`ifdef RD_BYPASS_EN
            if (w.a == ra) exp_rd = w.d;
`endif
        end
        chk("req_ready", {28'd0, req_ready}, {28'd0, er});
        chk("lock_active", {31'd0, lock_active}, {31'd0, ea});
        chk("lock_owner", {30'd0, lock_owner}, {30'd0, eo});
        chk("lock_timeout", {31'd0, lock_timeout}, {31'd0, et});
        chk("rd_data", rd_data, exp_rd);
        if (g >= 0) begin
            sbq.push_back(w);
            model[w.a] = w.d;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_all_zero(input string nm);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            chk(nm, rd_data, 32'h0);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_data  = '0;
        rd_addr   = '0;
        for (int i = 0; i < 8; i++) model[i] = '0;

        // Round-robin sweep, wrap-around, lock with stall and release
        tbl.push_back('{4'hF, 4'h0, 12'o3210, 32'hA0,  3'd0, 4'h1, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'hF, 4'h0, 12'o3210, 32'hA0,  3'd0, 4'h2, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'hF, 4'h0, 12'o3210, 32'hA0,  3'd1, 4'h4, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'hF, 4'h0, 12'o3210, 32'hA0,  3'd2, 4'h8, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'h2, 4'h0, 12'o6666, 32'h100, 3'd6, 4'h2, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'h9, 4'h0, 12'o6666, 32'h200, 3'd6, 4'h8, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'h9, 4'h0, 12'o6666, 32'h300, 3'd6, 4'h1, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'hF, 4'h2, 12'o5555, 32'h400, 3'd5, 4'h2, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'hF, 4'h2, 12'o5555, 32'h410, 3'd5, 4'h2, 1'b1, 2'd1, 1'b0});
        tbl.push_back('{4'hF, 4'h2, 12'o5555, 32'h420, 3'd5, 4'h2, 1'b1, 2'd1, 1'b0});
        tbl.push_back('{4'hF, 4'h2, 12'o5555, 32'h430, 3'd5, 4'h2, 1'b1, 2'd1, 1'b0});
        tbl.push_back('{4'hF, 4'h0, 12'o5555, 32'h440, 3'd5, 4'h2, 1'b1, 2'd1, 1'b0});
        tbl.push_back('{4'hF, 4'h0, 12'o3210, 32'h500, 3'd2, 4'h4, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'h8, 4'h8, 12'o0000, 32'h600, 3'd0, 4'h8, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'h7, 4'h0, 12'o0000, 32'h700, 3'd0, 4'h0, 1'b1, 2'd3, 1'b0});
        tbl.push_back('{4'h7, 4'h0, 12'o1111, 32'h800, 3'd1, 4'h1, 1'b0, 2'd0, 1'b0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {28'd0, req_ready}, 32'h0);
        chk("rst_lock_active", {31'd0, lock_active}, 32'h0);
        chk("rst_lock_owner", {30'd0, lock_owner}, 32'h0);
        chk("rst_lock_timeout", {31'd0, lock_timeout}, 32'h0);
        rst_n = 1'b1;
        read_all_zero("rst_regs");
        @(negedge clk);

        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].l, tbl[k].a, tbl[k].d, tbl[k].ra,
                 tbl[k].er, tbl[k].ea, tbl[k].eo, tbl[k].et);
        end

        // Requester 0 keeps its lock past LOCK_MAX; requester 1 waits
        for (int c = 0; c < 20; c++) begin
            step((c == 0) ? 4'h1 : 4'h3, 4'h1, 12'o0047,
                 32'h1000 + 32'(c * 16), 3'd7,
                 (c == 17) ? 4'h2 : 4'h1,
                 (c >= 1 && c <= 16) || c == 19, 2'd0, c == 17);
        end
        step(4'h0, 4'h0, 12'o0000, 32'h0, 3'd4, 4'h0, 1'b1, 2'd0, 1'b0);

        // Reset while locked, with a write pending
        step(4'h2, 4'h2, 12'o0000, 32'h9000, 3'd0, 4'h2, 1'b0, 2'd0, 1'b0);
        sb_pop();
        req_valid = 4'h2;
        req_lock  = 4'h2;
        req_data  = {4{32'h9999_9999}};
        #1;
        chk("pre_rst_lock_active", {31'd0, lock_active}, 32'h1);
        chk("pre_rst_lock_owner", {30'd0, lock_owner}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_lock_active", {31'd0, lock_active}, 32'h0);
        chk("async_lock_owner", {30'd0, lock_owner}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        req_lock  = '0;
        rst_n     = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = '0;
        sbq.delete();
        read_all_zero("post_rst_regs");
        @(negedge clk);

        // Same-cycle read of a register being written
        step(4'h2, 4'h0, 12'o0030, 32'hDEAD_BEEE, 3'd3, 4'h2, 1'b0, 2'd0, 1'b0);
        step(4'h0, 4'h0, 12'o0000, 32'h0, 3'd3, 4'h0, 1'b0, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
